// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a one-cycle-latency instruction memory,
// tracks the single outstanding request and hands fetched words to a
// valid/ready consumer in program order.
//
// state  | meaning
// FETCH  | issuing one address per cycle, loading returned data into the output register
// STALL  | output was blocked; the dropped request is re-issued this cycle
// HALTED | fetch stopped; output register drains, only br_valid or reset leaves
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        inflight_v_q;
  logic [31:0] inflight_pc_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic        halted_q;

  logic        can_load;
  logic        xfer;

  // Output register may take new data when empty or being consumed this edge.
  assign can_load = !out_valid_q || out_ready;
  assign xfer     = out_valid_q && out_ready;

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = halted_q;

  // Fetch FSM; priority is reset > redirect > halt > stall > normal fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= 32'h0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'h0;
      out_pc_q      <= 32'h0;
      halted_q      <= 1'b0;
    end else if (br_valid) begin
      // A transfer on this edge has already completed; everything younger is flushed.
      state_q      <= FETCH;
      pc_q         <= br_target;
      inflight_v_q <= 1'b0;
      out_valid_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else if (halt) begin
      state_q      <= HALTED;
      halted_q     <= 1'b1;
      inflight_v_q <= 1'b0;
      if (xfer) begin
        out_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (inflight_v_q && !can_load) begin
            // Returned word has nowhere to go: drop it and rewind to re-fetch it.
            pc_q         <= inflight_pc_q;
            inflight_v_q <= 1'b0;
            state_q      <= STALL;
          end else begin
            if (inflight_v_q) begin
              out_instr_q <= imem_data;
              out_pc_q    <= inflight_pc_q;
              out_valid_q <= 1'b1;
            end else if (xfer) begin
              out_valid_q <= 1'b0;
            end
            inflight_pc_q <= pc_q;
            inflight_v_q  <= 1'b1;
            pc_q          <= pc_q + 32'd1;
          end
        end
        STALL: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
          end
          inflight_pc_q <= pc_q;
          inflight_v_q  <= 1'b1;
          pc_q          <= pc_q + 32'd1;
          state_q       <= FETCH;
        end
        HALTED: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= FETCH;
          inflight_v_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed cycle-exact scenarios plus a randomized run
// checked against an in-order delivery model.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        br_valid;
  logic [31:0] br_target;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;
  bit use_hash = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .br_valid  (br_valid),
    .br_target (br_target),
    .halt      (halt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .halted    (halted)
  );

  // Preloaded program; the randomized phase fills other addresses with a hash
  // so that misrouted data is visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   mem_word = 32'h2200_0005;
      32'd1:   mem_word = 32'h2440_0003;
      32'd2:   mem_word = 32'hA800_0000;
      32'd3:   mem_word = 32'hA000_FFFD;
      default: mem_word = use_hash ? ((a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E) : 32'h0;
    endcase
  endfunction

  always @(posedge clk) imem_data <= mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; br_valid = 1'b0; halt = 1'b0; out_ready = 1'b1; br_target = 32'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) step();
    rst_n = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RPC); end
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL reset_outregs: got pc %h instr %h want 0 0", out_pc, out_instr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", halted); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      logic [31:0] ea;
      logic [31:0] ep;
      ea = 32'(c);
      ep = 32'(c - 2);
      if (c < 4) begin
        checks++; if (imem_addr !== ea) begin errors++; $display("FAIL seq_addr c%0d: got %h want %h", c, imem_addr, ea); end
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== ep || out_instr !== mem_word(ep)) begin
          errors++; $display("FAIL seq_out c%0d: got v%0b pc %h instr %h want v1 pc %h instr %h", c, out_valid, out_pc, out_instr, ep, mem_word(ep));
        end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_fill c%0d: got v%0b want 0", c, out_valid); end
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    int bubbles;
    do_reset();
    repeat (3) step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd1 || out_instr !== 32'h2440_0003) begin
        errors++; $display("FAIL stall_hold %0d: got v%0b pc %h instr %h want v1 pc 1 instr 24400003", i, out_valid, out_pc, out_instr);
      end
      step();
    end
    out_ready = 1'b1;
    exp_pc = 32'd1;
    bubbles = 0;
    for (int i = 0; i < 12 && exp_pc != 32'd4; i++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
          errors++; $display("FAIL stall_order: got pc %h instr %h want pc %h instr %h", out_pc, out_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd1;
      end else if (exp_pc != 32'd1) begin
        bubbles++;
      end
      step();
    end
    checks++; if (exp_pc !== 32'd4) begin errors++; $display("FAIL stall_timeout: got next pc %h want 4", exp_pc); end
    checks++; if (bubbles > 2) begin errors++; $display("FAIL stall_bubbles: got %0d want <=2", bubbles); end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (4) step();
    checks++; if (out_pc !== 32'd2) begin errors++; $display("FAIL br_pre: got pc %h want 2", out_pc); end
    br_valid = 1'b1; br_target = 32'h10;
    step();
    br_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL br_flush1: got v%0b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL br_flush2: got v%0b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ep;
      step();
      ep = 32'h10 + 32'(i);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== ep) begin
        errors++; $display("FAIL br_target %0d: got v%0b pc %h want v1 pc %h", i, out_valid, out_pc, ep);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (3) step();
    halt = 1'b1; out_ready = 1'b0;
    step();
    halt = 1'b0;
    checks++; if (halted !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'd1 || imem_addr !== 32'd3) begin
      errors++; $display("FAIL halt_enter: got h%0b v%0b pc %h addr %h want h1 v1 pc 1 addr 3", halted, out_valid, out_pc, imem_addr);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (halted !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'd3) begin
        errors++; $display("FAIL halt_drain %0d: got h%0b v%0b addr %h want h1 v0 addr 3", i, halted, out_valid, imem_addr);
      end
    end
    br_valid = 1'b1; br_target = 32'h0;
    step();
    br_valid = 1'b0;
    checks++; if (halted !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_exit: got h%0b v%0b want h0 v0", halted, out_valid); end
    step();
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h2200_0005) begin
      errors++; $display("FAIL halt_restart: got v%0b pc %h instr %h want v1 pc 0 instr 22000005", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (2) step();
    br_valid = 1'b1; br_target = 32'hFFFF_FFFF;
    step();
    br_valid = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_top: got v%0b pc %h want v1 pc ffffffff", out_valid, out_pc); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h2200_0005) begin
      errors++; $display("FAIL wrap_zero: got v%0b pc %h instr %h want v1 pc 0 instr 22000005", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_reset_stall();
    do_reset();
    repeat (3) step();
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || imem_addr !== RPC || halted !== 1'b0) begin
      errors++; $display("FAIL rststall_clear: got v%0b addr %h h%0b want v0 addr %h h0", out_valid, imem_addr, halted, RPC);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      logic [31:0] ep;
      ep = 32'(c - 2);
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== ep || out_instr !== mem_word(ep)) begin
          errors++; $display("FAIL rststall_seq c%0d: got v%0b pc %h instr %h want v1 pc %h", c, out_valid, out_pc, out_instr, ep);
        end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rststall_fill c%0d: got v%0b want 0", c, out_valid); end
      end
      step();
    end
  endtask

  // Model: each accepted word must be the next address in program order (or the
  // redirect target), carry that address's memory word, and stay put while blocked.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        m_halt;
    int          idle;
    logic        p_valid, xfer;
    logic [31:0] p_pc, p_instr;
    use_hash = 1'b1;
    do_reset();
    exp_pc = RPC; m_halt = 1'b0; idle = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      br_valid  = ($urandom_range(0, 29) == 0);
      br_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : 32'($urandom);
      halt      = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      p_valid = out_valid; p_pc = out_pc; p_instr = out_instr;
      xfer = out_valid && out_ready;
      step();
      if (!rst_n) begin
        checks++; if (out_valid !== 1'b0 || imem_addr !== RPC || halted !== 1'b0) begin
          errors++; $display("FAIL rnd_reset n%0d: got v%0b addr %h h%0b", n, out_valid, imem_addr, halted);
        end
        exp_pc = RPC; m_halt = 1'b0; idle = 0;
      end else begin
        if (xfer) begin
          checks++; if (p_pc !== exp_pc || p_instr !== mem_word(p_pc)) begin
            errors++; $display("FAIL rnd_order n%0d: got pc %h instr %h want pc %h instr %h", n, p_pc, p_instr, exp_pc, mem_word(exp_pc));
          end
          exp_pc = exp_pc + 32'd1;
        end
        if (br_valid) begin
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_brflush n%0d: got v%0b want 0", n, out_valid); end
          exp_pc = br_target; m_halt = 1'b0;
        end else begin
          if (halt) m_halt = 1'b1;
          if (p_valid && !out_ready) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== p_pc || out_instr !== p_instr) begin
              errors++; $display("FAIL rnd_hold n%0d: got v%0b pc %h instr %h want v1 pc %h instr %h", n, out_valid, out_pc, out_instr, p_pc, p_instr);
            end
          end
          if (m_halt) begin
            checks++; if (out_valid !== (p_valid && !out_ready)) begin
              errors++; $display("FAIL rnd_haltload n%0d: got v%0b want %0b", n, out_valid, p_valid && !out_ready);
            end
          end
        end
        checks++; if (halted !== m_halt) begin errors++; $display("FAIL rnd_halted n%0d: got %0b want %0b", n, halted, m_halt); end
        if (xfer || br_valid || halt || m_halt || !out_ready) begin
          idle = 0;
        end else begin
          idle++;
          checks++; if (idle > 3) begin errors++; $display("FAIL rnd_starve n%0d: got %0d idle ready cycles want <=3", n, idle); end
        end
      end
    end
    use_hash = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_target = 32'h0; halt = 1'b0; out_ready = 1'b1;
    test_reset();
    test_sequence();
    test_stall();
    test_branch();
    test_halt();
    test_wrap();
    test_reset_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  synchronous, active-low reset.
REQ-004 Port imem_addr  output  32  word address to instruction memory; driven directly from register pc_q.
REQ-005 Port imem_data  input  32  memory read data; holds mem[address sampled at the previous rising edge].
REQ-006 Port br_valid  input  1  redirect request.
REQ-007 Port br_target  input  32  redirect word address, qualified by br_valid.
REQ-008 Port halt  input  1  stop-fetch request.
REQ-009 Port out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-010 Port out_ready  input  1  downstream accepts; transfer when out_valid && out_ready at an edge.
REQ-011 Port out_instr  output  32  fetched instruction word.
REQ-012 Port out_pc  output  32  word address of out_instr.
REQ-013 Port halted  output  1  high while in state HALTED.

Function
REQ-014 Registers shall be pc_q, inflight_v, inflight_pc, out_valid, out_instr, out_pc, and state in {FETCH, STALL, HALTED}.
REQ-015 Memory read latency shall be one cycle: an address presented at edge k yields valid imem_data in cycle k+1 and is tracked by inflight_v/inflight_pc.
REQ-016 Event priority at every edge shall be: reset > br_valid > halt > stall > normal.
REQ-017 The output register shall be loadable (can_load) when !out_valid || out_ready.
REQ-018 In FETCH with inflight_v=1 and can_load: out_instr <= imem_data, out_pc <= inflight_pc, and out_valid <= 1.
REQ-019 In FETCH with no stall: inflight_pc <= pc_q, inflight_v <= 1, and pc_q <= pc_q+1.
REQ-020 A stall (FETCH, inflight_v=1, !can_load) shall drop imem_data, set pc_q <= inflight_pc and inflight_v <= 0, and enter STALL.
REQ-021 In STALL, the unit shall re-issue pc_q (inflight_pc <= pc_q, inflight_v <= 1, pc_q <= pc_q+1) and return to FETCH.
REQ-022 Whenever out_valid && out_ready and no new load occurs, out_valid <= 0.
REQ-023 The output register shall hold instr/pc stable while out_valid && !out_ready.
REQ-024 Each address shall be delivered exactly once, in program order, with no duplicate and no skip, across any out_ready pattern.
REQ-025 br_valid in any state shall set pc_q <= br_target, inflight_v <= 0, out_valid <= 0, and state <= FETCH.
REQ-026 A transfer coinciding with br_valid shall count as completed.
REQ-027 halt (without br_valid) shall enter HALTED, set inflight_v <= 0, freeze pc_q, and discard any in-flight data.
REQ-028 In HALTED, the output register shall drain normally and no new load shall occur.
REQ-029 HALTED shall be left only via br_valid or reset.
REQ-030 pc_q increment shall wrap modulo 2^32 (32'hFFFFFFFF -> 32'h00000000).
REQ-031 imem_addr shall be stable for the whole cycle, with no combinational path from any input.

Reset
REQ-032 rst_n=0 at an edge shall set pc_q=RESET_PC, inflight_v=0, out_valid=0, out_instr=0, out_pc=0, state=FETCH, and halted=0.
REQ-033 Reset shall take effect from any state, mid-stall or mid-branch included; a request in flight at that edge shall be discarded.
REQ-034 After rst_n rises (cycle 0): imem_addr=RESET_PC in cycle 0, and the first out_valid=1 shall appear in cycle 2.

Verification
Memory preload for all scenarios: mem[0]=22000005, mem[1]=24400003, mem[2]=A8000000, mem[3]=A000FFFD, rest 0.
REQ-035 Reset release with out_ready=1 -> imem_addr 0,1,2,3 in cycles 0-3; out_pc 0,1,2 in cycles 2-4; out_instr 22000005, 24400003, A8000000.
REQ-036 out_ready=0 for 3 cycles while out_pc=1 -> out_instr holds 24400003; on release, out_pc continues 2,3 with no duplicate or skip, and at most 2 bubble cycles.
REQ-037 br_valid=1, br_target=0x10 while out_pc=2 -> next cycle out_valid=0; out_pc=0x10 two cycles later; addresses 3 and 4 are never delivered.
REQ-038 halt=1 for one cycle -> halted=1, imem_addr frozen, out_valid falls after one accepted transfer; then br_valid with target 0 -> out_pc=0, out_instr=22000005 two cycles later.
REQ-039 br_target=32'hFFFFFFFF -> out_pc sequence FFFFFFFF, 00000000.
REQ-040 rst_n=0 during an active stall -> next cycle out_valid=0, imem_addr=RESET_PC; normal sequence restarts per REQ-035.
